uart_tx_arb: RTL
================

# uart_tx_arb

Round-robin arbiter that shares one `uart_tx` transmitter between `NUM_REQ` byte producers. It sits between the requesters and the transmitter's `i_data`/`i_write`/`o_busy` handshake. It grants one byte per arbitration, and holds further grants until the transmitter has started and finished that byte. A watchdog recovers the block if the transmitter never reports busy after a write.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `DATA_BITS`, 8: byte width; must match the transmitter.
- `BUSY_TIMEOUT`, 16: cycles to wait for `i_tx_busy` to rise after a write before aborting; legal range ≥2.
- `i_clk` input 1: system clock; all logic is on the rising edge.
- `i_rst_n` input 1: reset; asynchronous assert, active-low.
- `i_req` input `NUM_REQ`: per-requester byte request, level.
  - Held high with stable data until that requester's `o_grant` bit pulses.
- `i_data` input `NUM_REQ*DATA_BITS`: flattened request data; requester k occupies bits `[k*DATA_BITS +: DATA_BITS]`.
- `o_grant` output `NUM_REQ`: one-hot, one-cycle pulse; the byte of that requester was accepted.
- `o_tx_data` output `DATA_BITS`: registered byte to the transmitter `i_data`.
- `o_tx_write` output 1: one-cycle write strobe to the transmitter `i_write`.
- `i_tx_busy` input 1: transmitter `o_busy`.
- `o_busy` output 1: high whenever state ≠ IDLE.
- `o_err` output 1: one-cycle pulse on watchdog abort.

## Operation
- States:
  - IDLE: ready for a new arbitration.
  - WAIT_BUSY: write issued, waiting for the transmitter to go busy.
  - WAIT_DONE: byte in flight.
- Reset values:
  - state IDLE.
  - Round-robin pointer `ptr` = 0 (width `$clog2(NUM_REQ)`).
  - Watchdog counter 0.
  - Outputs: `o_grant`=0, `o_tx_data`=0, `o_tx_write`=0, `o_busy`=0, `o_err`=0.
- IDLE:
  - Arbitration fires when `|i_req` and `!i_tx_busy`.
  - Winner w = first asserted request found scanning upward from `ptr`, wrapping at `NUM_REQ-1` → 0.
  - Registered on that edge: `o_tx_data`←data[w], `o_tx_write`←1, `o_grant`←(1<<w), `ptr`←(w+1) mod `NUM_REQ`, counter←0, state←WAIT_BUSY.
  - With no request, or while `i_tx_busy` is high, the block stays in IDLE with all strobes low.
- WAIT_BUSY:
  - `o_tx_write` and `o_grant` clear on the first edge in this state, so each is exactly one cycle wide.
  - `i_tx_busy`=1 → WAIT_DONE.
  - Otherwise the counter increments. When counter = `BUSY_TIMEOUT-1` and busy is still low: state←IDLE, `o_err`←1 for one cycle. The granted byte is not re-requested.
- WAIT_DONE: `i_tx_busy`=0 → IDLE.
- `i_req` is ignored outside IDLE. A requester dropping its request before being granted loses nothing; it is simply not selected.
- `o_tx_data` holds its value until the next grant.
- Reset asserted mid-operation: all state clears immediately. A byte already latched by the transmitter completes on the line, and its busy is respected because IDLE requires `!i_tx_busy`.

## Timing
- Arbitration edge N:
  - `o_tx_write` and `o_grant` are high during cycle N+1.
  - `o_busy` is high from N+1.
- Transmitter raising busy one cycle after the write: WAIT_BUSY lasts 1 cycle.
- `i_tx_busy` falls at edge M: IDLE in cycle M+1; earliest next write strobe in cycle M+2.
- Watchdog abort: `o_err` is high in cycle N+1+`BUSY_TIMEOUT`, and state is IDLE in that same cycle.
- Requester protocol: see grant in cycle N+1, deassert or advance data by edge N+2. The arbiter does not sample `i_req` again before that.

## Configuration
- `UART_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins. `ptr` is not implemented, and the scan always starts at requester 0.
  - Undefined (default): round-robin as described above.
- All other behaviour and timing are identical in both builds.

## Test plan
- Single request: `i_req`=4'b0100, data2=8'hA5, busy model rises 1 cycle after write and holds for 10 cycles → one `o_tx_write` pulse with `o_tx_data`=8'hA5, `o_grant`=4'b0100, `o_busy` high for 12 cycles, `ptr`=3.
- Round-robin fairness: `i_req`=4'b1111 held, data k=8'h10+k → grant order 0,1,2,3,0, exactly one write per transmitter busy period. With `UART_ARB_FIXED_PRIO_EN` the order is 0,0,0.
- Wrap-around: `ptr`=3, `i_req`=4'b1001 → requester 3 granted, then requester 0.
- Watchdog: busy model never asserts → `o_err` pulses exactly 17 cycles after arbitration (`BUSY_TIMEOUT`=16), return to IDLE, next pending request granted.
- Busy at request: `i_tx_busy` high for 5 cycles when `i_req` rises → no write until busy has been low one cycle.
- Reset in WAIT_DONE: drop `i_rst_n` → all outputs 0 asynchronously. After release, the first grant goes to the lowest pending requester from `ptr`=0.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module uart_tx_arb #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*DATA_BITS-1:0] i_data,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic [DATA_BITS-1:0]         o_tx_data,
  output logic                         o_tx_write,
  input  logic                         i_tx_busy,
  output logic                         o_busy,
  output logic                         o_err
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   write_q;
  logic                   err_q;

  logic [PW-1:0]          scan_start;
  logic [PW-1:0]          win_sel;
  logic                   hit;
  logic                   fire;
  logic [NUM_REQ-1:0]     grant_d;
  logic [DATA_BITS-1:0]   data_d;
  logic [DATA_BITS-1:0]   req_data [NUM_REQ];

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_data[k] = i_data[k*DATA_BITS +: DATA_BITS];
    end
  end

  // Scan upward from scan_start with wrap; first asserted request wins.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    hit     = 1'b0;
    win_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(scan_start) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!hit && i_req[idx[PW-1:0]]) begin
        hit     = 1'b1;
        win_sel = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    grant_d          = '0;
    grant_d[win_sel] = 1'b1;
    data_d           = req_data[win_sel];
  end

  assign fire = (state_q == IDLE) && hit && !i_tx_busy;

`ifdef UART_ARB_FIXED_PRIO_EN
  assign scan_start = '0;
`else
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  assign ptr_d = (win_sel == PW'(NUM_REQ-1)) ? '0 : win_sel + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else if (fire) begin
      ptr_q <= ptr_d;
    end
  end

  assign scan_start = ptr_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      write_q <= 1'b0;
      grant_q <= '0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fire) begin
            data_q  <= data_d;
            write_q <= 1'b1;
            grant_q <= grant_d;
            cnt_q   <= '0;
            state_q <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (i_tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q == CW'(BUSY_TIMEOUT-1)) begin
            // Transmitter never took the byte; drop it and reopen arbitration.
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!i_tx_busy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_grant    = grant_q;
  assign o_tx_data  = data_q;
  assign o_tx_write = write_q;
  assign o_err      = err_q;
  assign o_busy     = (state_q != IDLE);

endmodule
